// File: rtl/pc_pkg.sv
// Shared definitions for the MicroMachine program-counter unit: next-PC
// select encoding, default vectors and a constant-width helper.
package pc_pkg;

    // Next-PC source, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_RET,
        SEL_EXC
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

    // Ceiling log2, used to size the RAS pointer at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full silently overwrites the
// oldest entry and sets a sticky overflow flag; push+pop together replaces
// the top entry (or behaves as a plain push when the stack is empty).
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf
);

    localparam int PTR_W = clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;      // next free slot; wraps naturally (power-of-2 depth)
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);

    // Resolve the push/pop request pair into exactly one stack operation.
    always_comb begin
        do_push    = push & (~pop | empty);
        do_pop     = pop & ~push & ~empty;
        do_replace = push & pop & ~empty;
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (do_push) begin
            ptr <= ptr + PTR_W'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage writes for push (including overwrite-oldest) and replace.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count==0 already marks every entry invalid.
        if (rst) begin
            if (do_push) begin
                mem[ptr] <= push_data;
            end else if (do_replace) begin
                mem[top_idx] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit at the head of the fetch stage: PC and EPC registers,
// prioritised next-PC selection (exc > ret > jump > branch > sequential),
// the sequential/branch adders and a return-address stack for call/return.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int               INC       = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             exc,
    input  logic             br_take,
    input  logic [WIDTH-1:0] br_off,
    input  logic             j_take,
    input  logic [WIDTH-1:0] j_target,
    input  logic             call,
    input  logic             ret_take,
    input  logic [WIDTH-1:0] ret_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] ret_pc;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] next_pc;
    logic             ras_push;
    logic             ras_pop;
    pc_sel_e          sel;

    // Arithmetic is modulo 2^WIDTH; the shift drops the offset's top two bits.
    assign pc_plus   = pc_q + WIDTH'(INC);
    assign br_target = pc_plus + (br_off << 2);
    assign ret_pc    = ras_empty ? ret_target : ras_top;

    // An exception suppresses any stack activity in the same cycle.
    assign ras_push = ena & ~exc & call;
    assign ras_pop  = ena & ~exc & ret_take;

    // Priority encoder for the next-PC source.
    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = SEL_SEQ;
        if (exc) begin
            sel = SEL_EXC;
        end else if (ret_take) begin
            sel = SEL_RET;
        end else if (j_take) begin
            sel = SEL_J;
        end else if (br_take) begin
            sel = SEL_BR;
        end
    end

    // Next-PC multiplexer driven by the selected source.
    always_comb begin
        next_pc = pc_plus;
        case (sel)
            SEL_EXC: next_pc = EXC_VEC;
            SEL_RET: next_pc = ret_pc;
            SEL_J:   next_pc = j_target;
            SEL_BR:  next_pc = br_target;
            default: next_pc = pc_plus;
        endcase
    end

    // PC and EPC registers; reset wins over ena, ena==0 freezes both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
        end else if (ena) begin
            pc_q <= next_pc;
            if (sel == SEL_EXC) begin
                epc_q <= pc_q;
            end
        end
    end

    assign pc_out = pc_q;
    assign epc    = epc_q;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit with hand-computed expectations,
// plus short sequences for RAS overflow, PC wrap-around and mid-run reset.
module tb_pc_unit;

    localparam int   WIDTH = 32;
    localparam logic L     = 1'b0;
    localparam logic H     = 1'b1;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             exc;
    logic             br_take;
    logic [WIDTH-1:0] br_off;
    logic             j_take;
    logic [WIDTH-1:0] j_target;
    logic             call;
    logic             ret_take;
    logic [WIDTH-1:0] ret_target;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] epc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        ena;
        logic        exc;
        logic        br_take;
        logic [31:0] br_off;
        logic        j_take;
        logic [31:0] j_target;
        logic        call;
        logic        ret_take;
        logic [31:0] ret_target;
        logic [31:0] exp_pc;
        logic [31:0] exp_epc;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .exc        (exc),
        .br_take    (br_take),
        .br_off     (br_off),
        .j_take     (j_take),
        .j_target   (j_target),
        .call       (call),
        .ret_take   (ret_take),
        .ret_target (ret_target),
        .pc_out     (pc_out),
        .pc_plus    (pc_plus),
        .epc        (epc),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_ovf    (ras_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic e, input logic x, input logic b, input logic [31:0] off,
        input logic j, input logic [31:0] jt, input logic c, input logic rt_take, input logic [31:0] rt,
        input logic [31:0] pc, input logic [31:0] ep, input logic emp, input logic ful, input logic ov);
        vec_t t;
        t.rst = r;       t.ena = e;        t.exc = x;
        t.br_take = b;   t.br_off = off;
        t.j_take = j;    t.j_target = jt;
        t.call = c;      t.ret_take = rt_take; t.ret_target = rt;
        t.exp_pc = pc;   t.exp_epc = ep;
        t.exp_empty = emp; t.exp_full = ful; t.exp_ovf = ov;
        return t;
    endfunction

    // Drive one cycle of inputs at the falling edge, check #1 after the rising edge.
    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        rst        = t.rst;
        ena        = t.ena;
        exc        = t.exc;
        br_take    = t.br_take;
        br_off     = t.br_off;
        j_take     = t.j_take;
        j_target   = t.j_target;
        call       = t.call;
        ret_take   = t.ret_take;
        ret_target = t.ret_target;
        @(posedge clk);
        #1;
        check({tag, " pc_out"},    pc_out,           t.exp_pc);
        check({tag, " pc_plus"},   pc_plus,          t.exp_pc + 32'd4);
        check({tag, " epc"},       epc,              t.exp_epc);
        check({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, t.exp_empty});
        check({tag, " ras_full"},  {31'd0, ras_full},  {31'd0, t.exp_full});
        check({tag, " ras_ovf"},   {31'd0, ras_ovf},   {31'd0, t.exp_ovf});
    endtask

    vec_t vecs [27];

    initial begin
        logic [31:0] cur;
        logic [31:0] ra [5];

        rst = 1'b0; ena = 1'b0; exc = 1'b0; br_take = 1'b0; br_off = '0;
        j_take = 1'b0; j_target = '0; call = 1'b0; ret_take = 1'b0; ret_target = '0;

        //             rst ena exc br  br_off         j   j_target       call ret ret_target     exp_pc         exp_epc        emp ful ovf
        vecs[0]  = mk(L, H, L, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'h0,         32'h0,         H, L, L);
        vecs[1]  = mk(L, L, L, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'h0,         32'h0,         H, L, L);
        vecs[2]  = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'h4,         32'h0,         H, L, L);
        vecs[3]  = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'h8,         32'h0,         H, L, L);
        vecs[4]  = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'hC,         32'h0,         H, L, L);
        vecs[5]  = mk(H, L, L, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'hC,         32'h0,         H, L, L);
        vecs[6]  = mk(H, L, L, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'hC,         32'h0,         H, L, L);
        vecs[7]  = mk(H, L, H, H, 32'h1,          H, 32'h40,       H, H, 32'h55,       32'hC,         32'h0,         H, L, L);
        vecs[8]  = mk(H, H, L, L, 32'h0,          H, 32'h100,      L, L, 32'h0,        32'h100,       32'h0,         H, L, L);
        vecs[9]  = mk(H, H, L, H, 32'hFFFF_FFFE,  L, 32'h0,        L, L, 32'h0,        32'h0FC,       32'h0,         H, L, L);
        vecs[10] = mk(H, H, L, L, 32'h0,          H, 32'h100,      L, L, 32'h0,        32'h100,       32'h0,         H, L, L);
        vecs[11] = mk(H, H, L, H, 32'hFFFF_FFFE,  H, 32'h400,      L, L, 32'h0,        32'h400,       32'h0,         H, L, L);
        vecs[12] = mk(H, H, L, L, 32'h0,          H, 32'h200,      L, L, 32'h0,        32'h200,       32'h0,         H, L, L);
        vecs[13] = mk(H, H, L, L, 32'h0,          H, 32'h800,      H, L, 32'h0,        32'h800,       32'h0,         L, L, L);
        vecs[14] = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'h804,       32'h0,         L, L, L);
        vecs[15] = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, H, 32'h999,      32'h204,       32'h0,         H, L, L);
        vecs[16] = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, H, 32'h999,      32'h999,       32'h0,         H, L, L);
        vecs[17] = mk(H, H, L, H, 32'h3,          L, 32'h0,        L, L, 32'h0,        32'h9A9,       32'h0,         H, L, L);
        vecs[18] = mk(H, H, L, L, 32'h0,          H, 32'h300,      H, L, 32'h0,        32'h300,       32'h0,         L, L, L);
        vecs[19] = mk(H, H, H, H, 32'h5,          H, 32'h40,       H, H, 32'h111,      32'h180,       32'h300,       L, L, L);
        vecs[20] = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, H, 32'h111,      32'h9AD,       32'h300,       H, L, L);
        vecs[21] = mk(H, H, H, L, 32'h0,          L, 32'h0,        L, L, 32'h0,        32'h180,       32'h9AD,       H, L, L);
        vecs[22] = mk(H, H, L, L, 32'h0,          H, 32'h500,      H, L, 32'h0,        32'h500,       32'h9AD,       L, L, L);
        vecs[23] = mk(H, H, L, L, 32'h0,          L, 32'h0,        H, H, 32'h111,      32'h184,       32'h9AD,       L, L, L);
        vecs[24] = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, H, 32'h111,      32'h504,       32'h9AD,       H, L, L);
        vecs[25] = mk(H, H, L, L, 32'h0,          L, 32'h0,        H, H, 32'h700,      32'h700,       32'h9AD,       L, L, L);
        vecs[26] = mk(H, H, L, L, 32'h0,          L, 32'h0,        L, H, 32'h111,      32'h508,       32'h9AD,       H, L, L);

        for (int i = 0; i < 27; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Five calls into a depth-4 stack: the fifth overwrites the oldest entry.
        cur = 32'h508;
        for (int i = 0; i < 5; i++) begin
            ra[i] = cur + 32'd4;
            cur   = 32'(i + 1) * 32'h1000;
            apply(mk(H, H, L, L, 32'h0, H, cur, H, L, 32'h0, cur, 32'h9AD, L, (i >= 3), (i == 4)),
                  $sformatf("call%0d", i));
        end

        // Four returns come back in LIFO order; the oldest (ra[0]) was lost.
        for (int i = 0; i < 4; i++) begin
            apply(mk(H, H, L, L, 32'h0, L, 32'h0, L, H, 32'hABC, ra[4 - i], 32'h9AD, (i == 3), L, H),
                  $sformatf("ret%0d", i));
        end
        apply(mk(H, H, L, L, 32'h0, L, 32'h0, L, H, 32'hABC, 32'hABC, 32'h9AD, H, L, H), "ret_empty");

        // Sequential step across the top of the address space.
        apply(mk(H, H, L, L, 32'h0, H, 32'hFFFF_FFFC, L, L, 32'h0, 32'hFFFF_FFFC, 32'h9AD, H, L, H), "wrap_jump");
        apply(mk(H, H, L, L, 32'h0, L, 32'h0, L, L, 32'h0, 32'h0, 32'h9AD, H, L, H), "wrap_seq");

        // Reset with two live entries discards them and clears the sticky flag.
        apply(mk(H, H, L, L, 32'h0, H, 32'h40, H, L, 32'h0, 32'h40, 32'h9AD, L, L, H), "pre_rst_call0");
        apply(mk(H, H, L, L, 32'h0, H, 32'h80, H, L, 32'h0, 32'h80, 32'h9AD, L, L, H), "pre_rst_call1");
        apply(mk(L, H, H, L, 32'h0, H, 32'h90, H, H, 32'h0, 32'h0, 32'h0, H, L, L), "mid_rst");
        apply(mk(H, H, L, L, 32'h0, L, 32'h0, L, H, 32'h777, 32'h777, 32'h0, H, L, L), "post_rst_ret");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
